// File: rtl/input_debouncer.sv
// Two-channel input debouncer: 2-flop synchronizer, run-length counter and
// registered output per channel, with one-cycle rise/fall pulses and a busy flag.

module input_debouncer_ch #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int CNT_W           = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic raw,
  output logic db,
  output logic rise,
  output logic fall,
  output logic busy
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             s1;
  logic             s2;
  logic [CNT_W-1:0] cnt;
  logic             out_q;
  logic             rise_q;
  logic             fall_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1     <= 1'b0;
      s2     <= 1'b0;
      cnt    <= '0;
      out_q  <= 1'b0;
      rise_q <= 1'b0;
      fall_q <= 1'b0;
    end else begin
      s1     <= raw;
      s2     <= s1;
      rise_q <= 1'b0;
      fall_q <= 1'b0;
      if (en) begin
        if (s2 == out_q) begin
          cnt <= '0;
        end else if (cnt == LAST) begin
          out_q  <= s2;
          cnt    <= '0;
          rise_q <= s2;
          fall_q <= ~s2;
        end else begin
          cnt <= cnt + CNT_W'(1);
        end
      end
    end
  end

  // A pulse that lands in a frozen (en=0) cycle is suppressed rather than delayed.
  assign db   = out_q;
  assign rise = rise_q & en;
  assign fall = fall_q & en;
  assign busy = (cnt != '0);

endmodule

module input_debouncer #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int CNT_W           = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic a_raw,
  input  logic b_raw,
  output logic a_db,
  output logic b_db,
  output logic a_rise,
  output logic a_fall,
  output logic b_rise,
  output logic b_fall,
  output logic busy
);

  logic a_busy;
  logic b_busy;

  input_debouncer_ch #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .CNT_W          (CNT_W)
  ) u_ch_a (
    .clk  (clk),
    .rst_n(rst_n),
    .en   (en),
    .raw  (a_raw),
    .db   (a_db),
    .rise (a_rise),
    .fall (a_fall),
    .busy (a_busy)
  );

  input_debouncer_ch #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .CNT_W          (CNT_W)
  ) u_ch_b (
    .clk  (clk),
    .rst_n(rst_n),
    .en   (en),
    .raw  (b_raw),
    .db   (b_db),
    .rise (b_rise),
    .fall (b_fall),
    .busy (b_busy)
  );

  assign busy = a_busy | b_busy;

endmodule

// File: tb/tb_input_debouncer.sv
// Bench for input_debouncer: directed scenarios with literal expectations plus
// randomized traffic checked every cycle against a sample-history model.

module tb_input_debouncer;

  localparam int N = 4;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  logic en    = 1'b1;
  logic a_raw = 1'b0;
  logic b_raw = 1'b0;
  logic a_db, b_db, a_rise, a_fall, b_rise, b_fall, busy;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  input_debouncer #(.DEBOUNCE_CYCLES(N), .CNT_W(16)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (en),
    .a_raw (a_raw),
    .b_raw (b_raw),
    .a_db  (a_db),
    .b_db  (b_db),
    .a_rise(a_rise),
    .a_fall(a_fall),
    .b_rise(b_rise),
    .b_fall(b_fall),
    .busy  (busy)
  );

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, got, exp);
    end
  endtask

  // Model: the value seen by the decision logic is the raw level sampled two
  // edges earlier; the output flips once the last N enabled samples taken
  // since the previous flip all disagree with it.
  bit m_out[2];
  bit m_chg[2];
  bit rq[2][$];
  bit sq[2][$];

  always @(posedge clk or negedge rst_n) begin
    bit raw_now[2];
    bit d;
    bit flip;
    if (!rst_n) begin
      for (int c = 0; c < 2; c++) begin
        m_out[c] = 1'b0;
        m_chg[c] = 1'b0;
        rq[c].delete();
        rq[c].push_back(1'b0);
        rq[c].push_back(1'b0);
        sq[c].delete();
      end
    end else begin
      raw_now[0] = a_raw;
      raw_now[1] = b_raw;
      for (int c = 0; c < 2; c++) begin
        d = rq[c][0];
        rq[c].push_back(raw_now[c]);
        void'(rq[c].pop_front());
        m_chg[c] = 1'b0;
        if (en) begin
          sq[c].push_back(d);
          if (sq[c].size() > N) void'(sq[c].pop_front());
          if (sq[c].size() == N) begin
            flip = 1'b1;
            for (int i = 0; i < sq[c].size(); i++)
              if (sq[c][i] == m_out[c]) flip = 1'b0;
            if (flip) begin
              m_out[c] = ~m_out[c];
              m_chg[c] = 1'b1;
              sq[c].delete();
            end
          end
        end
      end
    end
  end

  function automatic bit m_busy(input int c);
    if (sq[c].size() == 0) return 1'b0;
    return sq[c][sq[c].size()-1] != m_out[c];
  endfunction

  always @(negedge clk) begin
    logic [6:0] exp;
    exp = {m_out[0], m_out[1],
           m_chg[0] & m_out[0] & en, m_chg[0] & ~m_out[0] & en,
           m_chg[1] & m_out[1] & en, m_chg[1] & ~m_out[1] & en,
           m_busy(0) | m_busy(1)};
    check("model", {25'd0, a_db, b_db, a_rise, a_fall, b_rise, b_fall, busy}, {25'd0, exp});
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    // Reset asserts asynchronously before any clock edge.
    #1;
    a_raw = 1'b1;
    b_raw = 1'b1;
    rst_n = 1'b0;
    #1;
    check("reset_outs", {25'd0, a_db, b_db, a_rise, a_fall, b_rise, b_fall, busy}, 32'd0);
    a_raw = 1'b0;
    b_raw = 1'b0;
    tick(2);
    rst_n = 1'b1;

    // Clean rise on a.
    a_raw = 1'b1;
    for (int k = 1; k <= 7; k++) begin
      tick(1);
      check("rise_a_db",   a_db,   (k >= 6));
      check("rise_a_rise", a_rise, (k == 6));
      check("rise_busy",   busy,   (k >= 3 && k <= 5));
    end

    // Three-sample glitch on b is rejected.
    b_raw = 1'b1;
    for (int k = 1; k <= 9; k++) begin
      tick(1);
      if (k == 3) b_raw = 1'b0;
      check("glitch_b_db",   b_db,   1'b0);
      check("glitch_b_rise", b_rise, 1'b0);
      check("glitch_busy",   busy,   (k >= 3 && k <= 5));
    end

    // Bring b high, then drop both together.
    b_raw = 1'b1;
    tick(8);
    check("pre_fall_b_db", b_db, 1'b1);
    a_raw = 1'b0;
    b_raw = 1'b0;
    for (int k = 1; k <= 7; k++) begin
      tick(1);
      check("sfall_a_db",   a_db,   (k < 6));
      check("sfall_b_db",   b_db,   (k < 6));
      check("sfall_a_fall", a_fall, (k == 6));
      check("sfall_b_fall", b_fall, (k == 6));
    end

    // Reset mid-count discards the pending rise.
    a_raw = 1'b1;
    tick(4);
    rst_n = 1'b0;
    #1;
    check("midrst_a_db", a_db, 1'b0);
    check("midrst_busy", busy, 1'b0);
    #1;
    rst_n = 1'b1;
    for (int k = 1; k <= 7; k++) begin
      tick(1);
      check("postrst_a_db", a_db, (k >= 6));
    end

    // Enable freeze holds a count of two.
    a_raw = 1'b0;
    tick(4);
    en = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      tick(1);
      check("frz_a_db",   a_db,   1'b1);
      check("frz_a_fall", a_fall, 1'b0);
      check("frz_busy",   busy,   1'b1);
    end
    en = 1'b1;
    tick(1);
    check("unfrz1_a_db", a_db, 1'b1);
    tick(1);
    check("unfrz2_a_db",   a_db,   1'b0);
    check("unfrz2_a_fall", a_fall, 1'b1);

    // Random traffic: bouncy inputs, sporadic enable drops and resets.
    for (int i = 0; i < 4000; i++) begin
      tick(1);
      if ((i % 300) < 260) begin
        if ($urandom_range(0, 7) == 0) a_raw = ~a_raw;
        if ($urandom_range(0, 7) == 0) b_raw = ~b_raw;
      end
      en = ($urandom_range(0, 15) != 0);
      if ($urandom_range(0, 499) == 0) begin
        rst_n = 1'b0;
        #1;
        rst_n = 1'b1;
      end
    end

    tick(2);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
